// File: rtl/alu_op_sequencer_if.sv
// Request/response handshake and ALU control bus for the ALU front-end sequencer.
// The slave modport is the sequencer's view; master is the requester/ALU environment.
interface alu_op_sequencer_if #(
  parameter int unsigned WIDTH = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         in_op;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic [2:0]         alu_ctrl;
  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_b;
  logic [WIDTH-1:0]   alu_out;
  logic               alu_cout;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_result;
  logic               out_err;

  modport slave (
    input  in_valid, in_op, in_a, in_b, alu_out, alu_cout, out_ready,
    output in_ready, alu_ctrl, alu_a, alu_b, out_valid, out_result, out_err
  );

  modport master (
    output in_valid, in_op, in_a, in_b, alu_out, alu_cout, out_ready,
    input  in_ready, alu_ctrl, alu_a, alu_b, out_valid, out_result, out_err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Front-end controller for the 4-bit combinational ALU: single-cycle ops pass
// straight through, multiply is sequenced as shift-and-add on the ALU adder.
module alu_op_sequencer #(
  parameter int unsigned WIDTH  = 4,
  parameter logic [2:0]  MUL_OP = 3'b110
) (
  input logic               clk,
  input logic               rst_n,
  alu_op_sequencer_if.slave bus
);
  localparam int unsigned     CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [2:0]      RSVD_OP  = 3'b111;
  localparam logic [2:0]      ADD_OP   = 3'b010;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, EXEC, MULT, DONE} state_e;

  state_e               state_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic                 out_err_q;
  logic [2*WIDTH-1:0]   out_result_q;
  logic [2:0]           alu_ctrl_q;
  logic [WIDTH-1:0]     alu_a_q;
  logic [WIDTH-1:0]     alu_b_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [WIDTH-1:0]     mplr_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [WIDTH-1:0]     acc_d;
  logic [WIDTH-1:0]     mplr_d;
  logic                 accept_c;

  assign accept_c = bus.in_valid & in_ready_q;

  // One multiply step: {acc, mplr} = {cout, sum, mplr} >> 1; alu_a_q carries acc.
  always_comb begin
    acc_d  = {bus.alu_cout, bus.alu_out[WIDTH-1:1]};
    mplr_d = {bus.alu_out[0], mplr_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_err_q    <= 1'b0;
      out_result_q <= '0;
      alu_ctrl_q   <= 3'b000;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      mcand_q      <= '0;
      mplr_q       <= '0;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            in_ready_q <= 1'b0;
            if (bus.in_op == MUL_OP) begin
              state_q    <= MULT;
              alu_ctrl_q <= ADD_OP;
              alu_a_q    <= '0;
              alu_b_q    <= bus.in_b[0] ? bus.in_a : '0;
              mcand_q    <= bus.in_a;
              mplr_q     <= bus.in_b;
              cnt_q      <= '0;
            end else if (bus.in_op == RSVD_OP) begin
              // Reserved opcode is answered immediately without touching the ALU.
              state_q      <= DONE;
              out_valid_q  <= 1'b1;
              out_result_q <= '0;
              out_err_q    <= 1'b1;
            end else begin
              state_q    <= EXEC;
              alu_ctrl_q <= bus.in_op;
              alu_a_q    <= bus.in_a;
              alu_b_q    <= bus.in_b;
            end
          end
        end
        EXEC: begin
          state_q      <= DONE;
          out_valid_q  <= 1'b1;
          out_result_q <= {WIDTH'(0), bus.alu_out};
          out_err_q    <= 1'b0;
          alu_ctrl_q   <= 3'b000;
          alu_a_q      <= '0;
          alu_b_q      <= '0;
        end
        MULT: begin
          cnt_q  <= cnt_q + CNT_W'(1);
          mplr_q <= mplr_d;
          if (cnt_q == LAST_CNT) begin
            state_q      <= DONE;
            out_valid_q  <= 1'b1;
            out_result_q <= {acc_d, mplr_d};
            out_err_q    <= 1'b0;
            alu_ctrl_q   <= 3'b000;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
          end else begin
            alu_a_q <= acc_d;
            alu_b_q <= mplr_d[0] ? mcand_q : '0;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_err    = out_err_q;
  assign bus.alu_ctrl   = alu_ctrl_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Front-end controller for the 4-bit combinational ALU.
- Accepts one operation request at a time over a valid/ready handshake and drives the ALU control code (L,M,N) and operand buses.
- Captures the ALU result and returns it over a second valid/ready handshake.
- Implements 4-bit unsigned multiply as a multi-cycle shift-and-add sequence on the ALU's A+B path, filling the datapath's missing multiply function.

Parameters:
- WIDTH, 4, operand width; also the multiply iteration count.
- MUL_OP, 3'b110, request opcode selecting the sequenced multiply.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- in_valid  input  1  request present.
- in_ready  output  1  sequencer can accept a request.
- in_op  input  3  opcode: 000 -A, 001 -B, 010 A+B, 011 A-B, 100 A&B, 101 A|B, 110 MUL, 111 reserved.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- alu_ctrl  output  3  ALU control {L,M,N}.
- alu_a  output  WIDTH  ALU operand A.
- alu_b  output  WIDTH  ALU operand B.
- alu_out  input  WIDTH  ALU result; combinational from alu_ctrl/alu_a/alu_b.
- alu_cout  input  1  ALU adder carry-out; meaningful for code 010.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_result  output  2*WIDTH  result.
- out_err  output  1  request was a reserved opcode; valid with out_valid.

Behaviour:
- One clock domain. rst_n is synchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_result=0, out_err=0, alu_ctrl=000, alu_a=0, alu_b=0, iteration counter=0.
- States: IDLE, EXEC, MULT, DONE.
- in_ready=1 only in IDLE. A request is accepted on the edge where in_valid&in_ready; in_op, in_a and in_b are latched. Inputs are ignored in all other states.
- IDLE transitions on accept:
  - op 000..101: go to EXEC.
  - op MUL: go to MULT; acc=0, mplr=in_b, mcand=in_a, cnt=0.
  - op 111: go to DONE; out_result=0, out_err=1. The ALU is not driven.
- EXEC, one cycle:
  - alu_ctrl=latched op, alu_a=latched A, alu_b=latched B.
  - At the edge: out_result={WIDTH'b0, alu_out}, out_err=0, go to DONE.
  - Negate/subtract results are WIDTH-bit two's complement, zero-extended, never sign-extended.
- MULT, WIDTH cycles:
  - alu_ctrl=010, alu_a=acc, alu_b = mplr[0] ? mcand : 0.
  - At each edge: {acc, mplr} = {alu_cout, alu_out, mplr} >> 1, cnt=cnt+1.
  - After the edge where cnt==WIDTH-1: out_result={acc, mplr} as updated, out_err=0, go to DONE.
  - Result is the unsigned 2*WIDTH-bit product.
- DONE:
  - out_valid=1; out_result and out_err held stable.
  - Stay in DONE while out_ready=0.
  - On out_valid&out_ready: go to IDLE, out_valid=0. out_result holds its value; don't-care after that.
- Outside EXEC and MULT: alu_ctrl=000, alu_a=0, alu_b=0.
- Latency from accept edge T:
  - single op: out_valid high from T+2.
  - MUL: out_valid high from T+1+WIDTH (T+5 for WIDTH=4).
  - reserved op: out_valid high from T+1.
- Throughput: at most one request in flight. The next accept is possible at the first IDLE cycle after the output handshake; no bypass.
- Reset mid-operation: the in-flight request is discarded, no out_valid is produced, and all registers return to reset values at that edge.
- out_ready high outside DONE has no effect.
- in_valid held high in a non-IDLE state is not consumed.

Test Plan:
- A+B, a=1100, b=0001, out_ready=1 -> alu_ctrl=010 during EXEC; out_result=0x0D, out_err=0 at T+2; in_ready=1 the cycle after the handshake.
- -A, a=1100 -> alu_ctrl=000 during EXEC; out_result=0x04.
- MUL, a=1111, b=1111 -> exactly 4 MULT cycles with alu_ctrl=010; out_result=0xE1 at T+5.
- MUL, a=1010, b=0000 -> alu_b=0 in every MULT cycle; out_result=0x00.
- MUL, a=0111, b=0011 -> out_result=0x15.
- op 111 -> out_valid at T+1 with out_err=1 and out_result=0; alu_ctrl stays 000.
- Backpressure: A|B, a=0101, b=1010 with out_ready low for 3 cycles -> out_valid and out_result=0x0F held for 3 cycles; in_ready stays 0 and a second in_valid is not accepted; handshake completes on the first cycle out_ready is high.
- Reset: rst_n=0 on the second MULT cycle -> next cycle is IDLE, out_valid=0, out_result=0, in_ready=1; a fresh A-B request (0011, 0001) then yields 0x02.
